// File: rtl/coin_encoder.sv
// coin_encoder: debounces two coin sensors and serialises coin events into a one-cycle code stream
module coin_encoder #(
  parameter int DEB_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       inhibit,
  output logic [1:0] x,
  output logic       reject,
  output logic       busy
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  // channel index 0 is the 5-unit sensor, index 1 the 10-unit sensor
  logic [1:0]    sa, sb, deb, deb_d, ev;
  logic [CW-1:0] cnt [2];
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ, free;
  logic          pop, acc10, acc5, refuse;
  // synchronise, debounce and register one-cycle rising-edge events per channel
  always_ff @(posedge clk) begin
    if (!rst) begin
      sa    <= '0;
      sb    <= '0;
      deb   <= '0;
      deb_d <= '0;
      ev    <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sa    <= {coin10_raw, coin5_raw};
      sb    <= sa;
      deb_d <= deb;
      ev    <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sb[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // admission: free slots are counted before this cycle's pop, and 10 claims a slot ahead of 5
  always_comb begin
    free   = OW'(FIFO_DEPTH) - occ;
    pop    = occ != '0;
    acc10  = ev[1] & ~inhibit & (free != '0);
    acc5   = ev[0] & ~inhibit & (free > OW'(acc10));
    refuse = (ev[1] & ~acc10) | (ev[0] & ~acc5);
  end
  // queue storage needs no reset: only slots covered by occ are ever read
  always_ff @(posedge clk) begin
    if (acc10) mem[wp] <= 2'b10;
    if (acc5) mem[wp + AW'(acc10)] <= 2'b01;
  end
  // queue pointers, occupancy and registered outputs; one entry drains per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp     <= '0;
      rp     <= '0;
      occ    <= '0;
      x      <= 2'b00;
      reject <= 1'b0;
      busy   <= 1'b0;
    end else begin
      wp     <= wp + AW'(acc10) + AW'(acc5);
      rp     <= rp + AW'(pop);
      occ    <= occ + OW'(acc10) + OW'(acc5) - OW'(pop);
      x      <= pop ? mem[rp] : 2'b00;
      reject <= refuse;
      busy   <= pop;
    end
  end
endmodule
